// File: rtl/mux_logic_unit_if.sv
// Operand/result bus for mux_logic_unit; out_zero/out_parity exist only with MUX_LOGIC_FLAGS_EN.
// slave = the unit's view, master = the producer/consumer view.
interface mux_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] acc_q;
`ifdef MUX_LOGIC_FLAGS_EN
  logic             out_zero;
  logic             out_parity;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_data, acc_q, out_zero, out_parity
  );
  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, acc_q, out_zero, out_parity
  );
`else
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_data, acc_q
  );
  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, acc_q
  );
`endif
endinterface

// File: rtl/mux_logic_unit.sv
// Registered 2:1-mux logic unit with accumulator; 1-cycle latency, in_ready = ~out_valid | out_ready.
// Optional result flags (out_zero, out_parity) enabled by MUX_LOGIC_FLAGS_EN.
module mux_logic_unit #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_ACC = '0
) (
  input logic             clk,
  input logic             rst,
  mux_logic_unit_if.slave bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NOTA = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] acc_reg;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] mux_i0;
  logic [WIDTH-1:0] mux_i1;
  logic [WIDTH-1:0] result;

  function automatic logic mux2(input logic sel, input logic i0, input logic i1);
    return sel ? i1 : i0;
  endfunction

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // A clear in the same cycle as an accumulating op restarts the chain from zero.
  always_comb begin
    sel_a = bus.in_a;
    if (bus.in_acc) begin
      sel_a = bus.acc_clr ? '0 : acc_reg;
    end
  end

  always_comb begin
    mux_i0 = '0;
    mux_i1 = '0;
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (bus.in_op)
        OP_AND:  begin mux_i0[i] = 1'b0;          mux_i1[i] = bus.in_b[i];  end
        OP_OR:   begin mux_i0[i] = bus.in_b[i];   mux_i1[i] = 1'b1;         end
        OP_NAND: begin mux_i0[i] = 1'b1;          mux_i1[i] = ~bus.in_b[i]; end
        OP_NOR:  begin mux_i0[i] = ~bus.in_b[i];  mux_i1[i] = 1'b0;         end
        OP_NOTA: begin mux_i0[i] = 1'b1;          mux_i1[i] = 1'b0;         end
        OP_XOR:  begin mux_i0[i] = bus.in_b[i];   mux_i1[i] = ~bus.in_b[i]; end
        OP_XNOR: begin mux_i0[i] = ~bus.in_b[i];  mux_i1[i] = bus.in_b[i];  end
        OP_PASS: begin mux_i0[i] = bus.in_b[i];   mux_i1[i] = bus.in_b[i];  end
        default: begin mux_i0[i] = 1'b0;          mux_i1[i] = 1'b0;         end
      endcase
      result[i] = mux2(sel_a[i], mux_i0[i], mux_i1[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= result;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Updates on accept rather than on pop so accumulating ops chain back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= RESET_ACC;
    end else if (accept && bus.in_acc) begin
      acc_reg <= result;
    end else if (bus.acc_clr) begin
      acc_reg <= '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.acc_q     = acc_reg;

`ifdef MUX_LOGIC_FLAGS_EN
  logic zero_q;
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept) begin
      zero_q   <= ~(|result);
      parity_q <= ^result;
    end
  end

  assign bus.out_zero   = zero_q;
  assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_logic_unit.sv
// Directed self-checking bench for mux_logic_unit (WIDTH=8, RESET_ACC=0).
module tb_mux_logic_unit;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mux_logic_unit_if #(.WIDTH(WIDTH)) bus ();

  mux_logic_unit #(.WIDTH(WIDTH), .RESET_ACC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic acc, input logic clr);
    bus.in_valid = vld;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_acc   = acc;
    bus.acc_clr  = clr;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sweep_exp = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'h0F, 8'hCC, 8'h33, 8'h3C};
    rst = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h00);
    check("rst_acc_q",     32'(bus.acc_q),     32'h00);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    tick();
    rst = 1'b0;

    // AND / OR / XOR back-to-back
    drive(1'b1, 3'b000, 8'hCC, 8'hAA, 1'b0, 1'b0);
    tick();
    check("and_data",  32'(bus.out_data),  32'h88);
    check("and_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b1, 3'b001, 8'hCC, 8'hAA, 1'b0, 1'b0);
    tick();
    check("or_data",  32'(bus.out_data),  32'hEE);
    check("or_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b1, 3'b101, 8'hCC, 8'hAA, 1'b0, 1'b0);
    tick();
    check("xor_data",  32'(bus.out_data),  32'h66);
    check("xor_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Opcode sweep a=F0 b=3C
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 3'(k), 8'hF0, 8'h3C, 1'b0, 1'b0);
      tick();
      check($sformatf("sweep_op%0d", k), 32'(bus.out_data), 32'(sweep_exp[k]));
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();

    // Backpressure
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 8'hFF, 8'h5A, 1'b0, 1'b0);
    tick();
    check("bp_first_data", 32'(bus.out_data), 32'h5A);
    drive(1'b1, 3'b111, 8'h00, 8'hA5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready), 32'd0);
      tick();
      check($sformatf("bp_hold_data_%0d", k), 32'(bus.out_data), 32'h5A);
      check($sformatf("bp_hold_valid_%0d", k), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_ready_rise", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_second_data",  32'(bus.out_data),  32'hA5);
    check("bp_second_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check("bp_drain_valid", 32'(bus.out_valid), 32'd0);

    // Accumulate chain: clear+OR 01, OR 80, XOR FF
    drive(1'b1, 3'b001, 8'h00, 8'h01, 1'b1, 1'b1);
    tick();
    check("acc1_acc",  32'(bus.acc_q),    32'h01);
    check("acc1_data", 32'(bus.out_data), 32'h01);
    drive(1'b1, 3'b001, 8'h00, 8'h80, 1'b1, 1'b0);
    tick();
    check("acc2_acc",  32'(bus.acc_q),    32'h81);
    check("acc2_data", 32'(bus.out_data), 32'h81);
    drive(1'b1, 3'b101, 8'h00, 8'hFF, 1'b1, 1'b0);
    tick();
    check("acc3_acc",  32'(bus.acc_q),    32'h7E);
    check("acc3_data", 32'(bus.out_data), 32'h7E);

    // Stall with a held result, then async reset mid-cycle
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b111, 8'h00, 8'h12, 1'b0, 1'b0);
    tick();
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    check("stall_acc",   32'(bus.acc_q),     32'h7E);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data",  32'(bus.out_data),  32'h00);
    check("arst_acc",   32'(bus.acc_q),     32'h00);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // NOT A on the accumulator, then a standalone clear
    drive(1'b1, 3'b100, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    check("nota_acc", 32'(bus.acc_q), 32'hFF);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    check("clr_only_acc", 32'(bus.acc_q), 32'h00);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();

`ifdef MUX_LOGIC_FLAGS_EN
    drive(1'b1, 3'b000, 8'h0F, 8'hF0, 1'b0, 1'b0);
    tick();
    check("flag_and_zero",   32'(bus.out_zero),   32'd1);
    check("flag_and_parity", 32'(bus.out_parity), 32'd0);
    drive(1'b1, 3'b101, 8'h01, 8'h00, 1'b0, 1'b0);
    tick();
    check("flag_xor_zero",   32'(bus.out_zero),   32'd0);
    check("flag_xor_parity", 32'(bus.out_parity), 32'd1);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
